// File: rtl/tpu_pkg.sv
// Shared TPU definitions: sequencer state encoding and default array/buffer geometry.
package tpu_pkg;

  localparam int ARRAY_N_DEF = 16;
  localparam int ADDR_W_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WLOAD   = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/mmu_delay.sv
// mmu_delay: DEPTH-stage 1-bit shift register with hold enable, used to track
// which array cycles will produce a result row at the bottom edge.
module mmu_delay #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_d,
  output logic o_q
);

  logic [DEPTH-1:0] r_sr;

  // NOTE: this line is reset because a bit left over from an aborted tile would
  // otherwise surface later as a spurious result write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr <= '0;
    end else if (i_en) begin
      r_sr <= (r_sr << 1) | DEPTH'(i_d);
    end
  end

  assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/mmu_sched.sv
// mmu_sched: weight-load / compute / drain sequencer for one systolic-array tile.
// Optional stall-cycle counter output stall_cnt when MMU_SCHED_PERFCNT_EN is defined.
module mmu_sched
  import tpu_pkg::*;
#(
  parameter int ARRAY_N    = ARRAY_N_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int RESULT_LAT = 2 * ARRAY_N
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_rows,
  input  logic [ADDR_W-1:0] wbase,
  input  logic [ADDR_W-1:0] ibase,
  input  logic [ADDR_W-1:0] obase,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic              wbuf_rd,
  output logic [ADDR_W-1:0] wbuf_addr,
  output logic              mmu_wwrite,
  output logic              ibuf_rd,
  output logic [ADDR_W-1:0] ibuf_addr,
  output logic              mmu_active,
  output logic              obuf_wr,
  output logic [ADDR_W-1:0] obuf_addr
`ifdef MMU_SCHED_PERFCNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  state_e            r_state;
  logic [ADDR_W-1:0] r_num_rows;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_ocnt;
  logic [ADDR_W-1:0] r_waddr;
  logic [ADDR_W-1:0] r_iaddr;
  logic [ADDR_W-1:0] r_oaddr;
  logic              w_busy;
  logic              w_adv;
  logic              w_dly_q;

  assign w_busy = (r_state == ST_WLOAD) || (r_state == ST_COMPUTE) || (r_state == ST_DRAIN);
  // Stall only freezes the sequencer while a tile is in flight.
  assign w_adv  = !(stall && w_busy);

  assign busy       = w_busy;
  assign done       = (r_state == ST_DONE);
  assign wbuf_rd    = (r_state == ST_WLOAD) && w_adv;
  assign mmu_wwrite = wbuf_rd;
  assign ibuf_rd    = (r_state == ST_COMPUTE) && w_adv;
  assign mmu_active = ibuf_rd;
  assign obuf_wr    = w_dly_q && w_adv;
  assign wbuf_addr  = r_waddr;
  assign ibuf_addr  = r_iaddr;
  assign obuf_addr  = r_oaddr;

  mmu_delay #(.DEPTH(RESULT_LAT)) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_adv),
    .i_d   (mmu_active),
    .o_q   (w_dly_q)
  );

  // NOTE: non-blocking assignments everywhere here, so every register update in
  // a cycle is computed from the values present before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_num_rows <= '0;
      r_cnt      <= '0;
      r_ocnt     <= '0;
      r_waddr    <= '0;
      r_iaddr    <= '0;
      r_oaddr    <= '0;
    end else begin
      if (obuf_wr) begin
        r_oaddr <= r_oaddr + ADDR_W'(1);
        r_ocnt  <= r_ocnt + ADDR_W'(1);
      end
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_num_rows <= num_rows;
            r_waddr    <= wbase;
            r_iaddr    <= ibase;
            r_oaddr    <= obase;
            r_cnt      <= '0;
            r_ocnt     <= '0;
            r_state    <= ST_WLOAD;
          end
        end
        ST_WLOAD: begin
          if (!stall) begin
            r_waddr <= r_waddr + ADDR_W'(1);
            if (r_cnt == ADDR_W'(ARRAY_N - 1)) begin
              r_cnt   <= '0;
              r_state <= (r_num_rows == '0) ? ST_DONE : ST_COMPUTE;
            end else begin
              r_cnt <= r_cnt + ADDR_W'(1);
            end
          end
        end
        ST_COMPUTE: begin
          if (!stall) begin
            r_iaddr <= r_iaddr + ADDR_W'(1);
            if (r_cnt == r_num_rows - ADDR_W'(1)) begin
              r_state <= ST_DRAIN;
            end else begin
              r_cnt <= r_cnt + ADDR_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          // Results can start landing during COMPUTE; only the final one ends the tile.
          if (obuf_wr && (r_ocnt == r_num_rows - ADDR_W'(1))) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef MMU_SCHED_PERFCNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_stall_cnt <= '0;
    end else if (w_busy && stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_mmu_sched.sv
// Self-checking bench for mmu_sched (ARRAY_N=4): directed table, a reset-abort
// sequence and randomized tiles against a cycle-count reference model.
module tb_mmu_sched;

  localparam int AN = 4;
  localparam int AW = 8;
  localparam int RL = 2 * AN;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] num_rows, wbase, ibase, obase;
  logic          stall;
  logic          busy, done, wbuf_rd, mmu_wwrite, ibuf_rd, mmu_active, obuf_wr;
  logic [AW-1:0] wbuf_addr, ibuf_addr, obuf_addr;
`ifdef MMU_SCHED_PERFCNT_EN
  logic [31:0]   stall_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int            m;
    logic [AW-1:0] wb;
    logic [AW-1:0] ib;
    logic [AW-1:0] ob;
    int            mode;        // 0 no stall, 1 stall window, 2 random stall
    int            s_at;
    int            s_len;
    int            restart_at;  // busy-cycle index of an extra start pulse, -1 none
    int            exp_done_c;  // busy-cycle index of done, -1 unchecked
  } vec_t;

  vec_t tbl[6];

  mmu_sched #(.ARRAY_N(AN), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_rows   (num_rows),
    .wbase      (wbase),
    .ibase      (ibase),
    .obase      (obase),
    .stall      (stall),
    .busy       (busy),
    .done       (done),
    .wbuf_rd    (wbuf_rd),
    .wbuf_addr  (wbuf_addr),
    .mmu_wwrite (mmu_wwrite),
    .ibuf_rd    (ibuf_rd),
    .ibuf_addr  (ibuf_addr),
    .mmu_active (mmu_active),
    .obuf_wr    (obuf_wr),
    .obuf_addr  (obuf_addr)
`ifdef MMU_SCHED_PERFCNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_outputs"},
          {1'b0, busy, done, wbuf_rd, mmu_wwrite, ibuf_rd, mmu_active, obuf_wr,
           wbuf_addr, ibuf_addr, obuf_addr}, 32'd0);
  endtask

  // Model: count the unstalled busy cycles u since the tile began. Weight reads
  // occupy u in [0,AN), input reads [AN,AN+m), result writes [AN+RL,AN+RL+m);
  // done follows the last busy cycle. Called just after a rising edge.
  task automatic run_tile(input vec_t v);
    int            u, total, nst, n_w, n_i, n_o;
    bit            fin, e_busy, act, e_w, e_i, e_o;
    logic [AW-1:0] ea;
    total = (v.m == 0) ? AN : AN + RL + v.m;
    u = 0; nst = 0; n_w = 0; n_i = 0; n_o = 0; fin = 1'b0;
    num_rows = AW'(v.m);
    wbase    = v.wb;
    ibase    = v.ib;
    obase    = v.ob;
    start    = 1'b1;
    stall    = (v.mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_wbuf_rd", wbuf_rd, 0);
    for (int c = 0; c < 400 && !fin; c++) begin
      @(posedge clk);
      #1;
      start = (c == v.restart_at);
      if (start) begin
        num_rows = AW'($urandom);
        wbase    = AW'($urandom);
        ibase    = AW'($urandom);
        obase    = AW'($urandom);
      end
      case (v.mode)
        1:       stall = (c >= v.s_at) && (c < v.s_at + v.s_len);
        2:       stall = ($urandom_range(0, 3) == 0);
        default: stall = 1'b0;
      endcase
      @(negedge clk);
      e_busy = (u < total);
      act    = e_busy && !stall;
      e_w    = act && (u < AN);
      e_i    = act && (u >= AN) && (u < AN + v.m);
      e_o    = act && (u >= AN + RL) && (u < AN + RL + v.m);
      check("busy", busy, e_busy);
      check("done", done, !e_busy);
      check("wbuf_rd", wbuf_rd, e_w);
      check("mmu_wwrite", mmu_wwrite, e_w);
      check("ibuf_rd", ibuf_rd, e_i);
      check("mmu_active", mmu_active, e_i);
      check("obuf_wr", obuf_wr, e_o);
      if (e_w) begin
        ea = v.wb + AW'(u);
        check("wbuf_addr", wbuf_addr, ea);
      end
      if (e_i) begin
        ea = v.ib + AW'(u - AN);
        check("ibuf_addr", ibuf_addr, ea);
      end
      if (e_o) begin
        ea = v.ob + AW'(u - AN - RL);
        check("obuf_addr", obuf_addr, ea);
      end
      n_w += int'(wbuf_rd);
      n_i += int'(ibuf_rd);
      n_o += int'(obuf_wr);
      if (e_busy && stall) nst++;
      if (act) u++;
      if (!e_busy) begin
        fin = 1'b1;
        if (v.exp_done_c >= 0) check("done_cycle", c, v.exp_done_c);
        check("n_wbuf_rd", n_w, AN);
        check("n_ibuf_rd", n_i, v.m);
        check("n_obuf_wr", n_o, v.m);
`ifdef MMU_SCHED_PERFCNT_EN
        check("stall_cnt", stall_cnt, nst);
`endif
      end
    end
    if (!fin) check("tile_timeout", 0, 1);
    @(posedge clk);
    #1;
    start = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    check("post_done", done, 0);
    check("post_busy", busy, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{3,  8'h10, 8'h20, 8'h30, 0, 0,  0, -1, 15};
    tbl[1] = '{3,  8'h10, 8'h20, 8'h30, 1, 5,  2, -1, 17};
    tbl[2] = '{0,  8'h10, 8'h20, 8'h30, 0, 0,  0, -1, 4};
    tbl[3] = '{3,  8'h10, 8'hFE, 8'h30, 0, 0,  0, 5,  15};
    tbl[4] = '{5,  8'hFD, 8'hF0, 8'hFE, 1, 1,  3, -1, 20};
    tbl[5] = '{10, 8'h00, 8'h40, 8'h80, 1, 12, 2, -1, 24};

    rst_n = 1'b1; start = 1'b0; stall = 1'b0;
    num_rows = '0; wbase = '0; ibase = '0; obase = '0;
    #3 rst_n = 1'b0;
    stall = 1'b1;
    #9 check_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stall = 1'b0;

    for (int i = 0; i < 6; i++) run_tile(tbl[i]);

    // Abort a tile in DRAIN: outputs clear at once, no done, restart on first clock.
    num_rows = 8'd3; wbase = 8'h10; ibase = 8'h20; obase = 8'h30;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    check("pre_abort_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_zero("abort");
    repeat (3) begin
      @(negedge clk);
      check("abort_done", done, 0);
      check("abort_busy", busy, 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_tile(tbl[0]);

    for (int t = 0; t < 25; t++) begin
      vec_t rv;
      rv.m          = $urandom_range(0, 20);
      rv.wb         = AW'($urandom);
      rv.ib         = AW'($urandom);
      rv.ob         = AW'($urandom);
      rv.mode       = 2;
      rv.s_at       = 0;
      rv.s_len      = 0;
      rv.restart_at = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 10) : -1;
      rv.exp_done_c = -1;
      run_tile(rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mmu_sched.md
MMU_SCHED -- requirements
Module: mmu_sched

Interface
REQ-001 SHALL provide parameter ARRAY_N, default 16: systolic array dimension (rows = columns of PEs).
REQ-002 SHALL provide parameter ADDR_W, default 8: buffer address width.
REQ-003 SHALL provide parameter RESULT_LAT, default 2*ARRAY_N: cycles from an active row entering the array to its result row becoming valid at the bottom edge.
REQ-004 SHALL have port clk  input  1  single system clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  one-cycle request to run one tile.
REQ-007 SHALL have port num_rows  input  ADDR_W  input rows to stream (M), sampled on accepted start.
REQ-008 SHALL have port wbase / ibase / obase  input  ADDR_W each  weight / input / output buffer base addresses, sampled on accepted start.
REQ-009 SHALL have port stall  input  1  input buffer empty or output buffer full; freezes the sequencer.
REQ-010 SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-011 SHALL have port done  output  1  one-cycle pulse when the tile completes.
REQ-012 SHALL have port wbuf_rd / wbuf_addr  output  1 / ADDR_W  weight row read strobe and address.
REQ-013 SHALL have port mmu_wwrite  output  1  drives wwrite of the array's first PE row.
REQ-014 SHALL have port ibuf_rd / ibuf_addr  output  1 / ADDR_W  input row read strobe and address.
REQ-015 SHALL have port mmu_active  output  1  drives active of the array's first PE column.
REQ-016 SHALL have port obuf_wr / obuf_addr  output  1 / ADDR_W  result row write strobe and address.

Function
REQ-017 SHALL implement states IDLE, WLOAD, COMPUTE, DRAIN and DONE.
REQ-018 In IDLE, start SHALL latch the configuration and move to WLOAD; start outside IDLE SHALL be ignored.
REQ-019 WLOAD SHALL last exactly ARRAY_N unstalled cycles, asserting wbuf_rd and mmu_wwrite with wbuf_addr = wbase+k, k = 0..ARRAY_N-1.
REQ-020 COMPUTE SHALL last num_rows unstalled cycles, asserting ibuf_rd and mmu_active with ibuf_addr = ibase+r, r = 0..num_rows-1.
REQ-021 num_rows = 0 SHALL take the FSM from WLOAD directly to DONE, with no ibuf_rd and no obuf_wr.
REQ-022 The FSM SHALL pass from COMPUTE to DRAIN, remain in DRAIN until the last obuf_wr, then go to DONE.
REQ-023 DONE SHALL last one cycle, pulse done and return to IDLE; busy SHALL be low in that cycle.
REQ-024 obuf_wr SHALL equal mmu_active delayed by RESULT_LAT unstalled cycles; obuf_addr = obase+n for the n-th write.
REQ-025 While stall is high: all strobes (wbuf_rd, mmu_wwrite, ibuf_rd, mmu_active, obuf_wr) SHALL be low; counters, addresses, the delay line and the state SHALL hold.
REQ-026 A stall that clears SHALL resume the sequence without skipping or duplicating any address.
REQ-027 stall SHALL be ignored in IDLE and DONE.
REQ-028 Address arithmetic SHALL wrap modulo 2^ADDR_W.

Reset
REQ-029 rst_n low SHALL immediately force IDLE and clear the delay line and counters.
REQ-030 During reset all outputs SHALL be 0.
REQ-031 Reset asserted mid-tile SHALL abort the tile with no done pulse.
REQ-032 After reset release the block SHALL accept start on the first clock.

Configuration
REQ-033 With macro MMU_SCHED_PERFCNT_EN defined, the block SHALL add output stall_cnt (32 bits), counting cycles with busy and stall both high.
REQ-034 stall_cnt SHALL be cleared by reset and on each accepted start, and SHALL saturate at all-ones.
REQ-035 Without MMU_SCHED_PERFCNT_EN, neither the port nor the counter SHALL exist.

Structure
REQ-036 Shared package tpu_pkg SHALL hold the FSM state enum, the ARRAY_N default and the ADDR_W default.
REQ-037 The RESULT_LAT delay line SHALL be sub-module mmu_delay: parameterised depth, 1-bit shift register with hold enable, async active-low reset.

Verification
REQ-038 ARRAY_N=4, num_rows=3, wbase=0x10, ibase=0x20, obase=0x30, no stall -> wbuf_addr 0x10..0x13 over 4 cycles; ibuf_addr 0x20..0x22; obuf_wr 8 cycles after each active, at 0x30..0x32; done 1 cycle after the last write.
REQ-039 Same configuration with stall high for 2 cycles mid-COMPUTE -> strobes low for those 2 cycles, address sequence unchanged, done 2 cycles later than REQ-038.
REQ-040 num_rows=0 -> 4 weight reads, then done, with no ibuf_rd and no obuf_wr.
REQ-041 start pulsed again during COMPUTE -> ignored, single done; ibase=0xFE with num_rows=3 -> ibuf_addr 0xFE, 0xFF, 0x00.
REQ-042 rst_n low in DRAIN -> all outputs 0 at once, no done; a new start after release runs a full tile.
REQ-043 With MMU_SCHED_PERFCNT_EN defined and the stall from REQ-039 -> stall_cnt = 2 at done.
